// File: rtl/dmem_arb.sv
// Two-requester data-memory arbiter: cpu has fixed priority, dbg gets
// starvation protection and a bounded lock for atomic multi-word sequences.
module dmem_arb #(
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned DATA_WIDTH   = 24,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned LOCK_MAX     = 8
) (
    input  logic                  iw_clk,
    input  logic                  iw_rst_n,
    input  logic                  iw_cpu_req,
    input  logic                  iw_cpu_we,
    input  logic [ADDR_WIDTH-1:0] iw_cpu_addr,
    input  logic [DATA_WIDTH-1:0] iw_cpu_wdata,
    output logic                  ow_cpu_gnt,
    output logic                  ow_cpu_stall,
    output logic                  or_cpu_rvalid,
    output logic [DATA_WIDTH-1:0] or_cpu_rdata,
    input  logic                  iw_dbg_req,
    input  logic                  iw_dbg_we,
    input  logic                  iw_dbg_lock,
    input  logic [ADDR_WIDTH-1:0] iw_dbg_addr,
    input  logic [DATA_WIDTH-1:0] iw_dbg_wdata,
    output logic                  ow_dbg_gnt,
    output logic                  or_dbg_rvalid,
    output logic [DATA_WIDTH-1:0] or_dbg_rdata,
    output logic                  ow_mem_en,
    output logic                  ow_mem_we,
    output logic [ADDR_WIDTH-1:0] ow_mem_addr,
    output logic [DATA_WIDTH-1:0] ow_mem_wdata,
    input  logic [DATA_WIDTH-1:0] iw_mem_rdata
);

    typedef enum logic {StShared, StLock} state_e;
    typedef enum logic [1:0] {PendNone, PendCpu, PendDbg} pend_e;

    localparam logic [3:0] StarveLim = 4'(STARVE_LIMIT);
    localparam logic [7:0] LockMax   = 8'(LOCK_MAX);

    state_e                state_q, state_d;
    pend_e                 pend_q, pend_d;
    logic [3:0]            wait_q, wait_d;
    logic [7:0]            lock_cnt_q, lock_cnt_d;
    logic [7:0]            lock_next;
    logic                  mask_q, mask_d;
    logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_WIDTH-1:0] dbg_rdata_q, dbg_rdata_d;
    logic                  locked;

    // Dropping the lock takes effect in the same cycle: arbitrate as shared.
    always_comb begin
        locked     = (state_q == StLock) && iw_dbg_lock;
        ow_cpu_gnt = 1'b0;
        ow_dbg_gnt = 1'b0;
        if (locked) begin
            ow_dbg_gnt = iw_dbg_req;
        end else begin
            ow_dbg_gnt = iw_dbg_req && !mask_q && (!iw_cpu_req || wait_q == StarveLim);
            ow_cpu_gnt = iw_cpu_req && !ow_dbg_gnt;
        end
        ow_cpu_stall = iw_cpu_req && !ow_cpu_gnt;
    end

    always_comb begin
        ow_mem_en    = ow_cpu_gnt || ow_dbg_gnt;
        ow_mem_we    = 1'b0;
        ow_mem_addr  = '0;
        ow_mem_wdata = '0;
        if (ow_dbg_gnt) begin
            ow_mem_we    = iw_dbg_we;
            ow_mem_addr  = iw_dbg_addr;
            ow_mem_wdata = iw_dbg_wdata;
        end else if (ow_cpu_gnt) begin
            ow_mem_we    = iw_cpu_we;
            ow_mem_addr  = iw_cpu_addr;
            ow_mem_wdata = iw_cpu_wdata;
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        mask_d     = 1'b0;
        lock_next  = lock_cnt_q + 8'd1;

        if (!iw_dbg_req || ow_dbg_gnt) begin
            wait_d = 4'd0;
        end else if (wait_q < StarveLim) begin
            wait_d = wait_q + 4'd1;
        end else begin
            wait_d = wait_q;
        end

        // Reaching LOCK_MAX forces one cycle with dbg masked so cpu can get in.
        if (locked) begin
            if (ow_dbg_gnt) begin
                if (lock_next >= LockMax) begin
                    state_d    = StShared;
                    lock_cnt_d = 8'd0;
                    mask_d     = 1'b1;
                end else begin
                    lock_cnt_d = lock_next;
                end
            end
        end else if (ow_dbg_gnt && iw_dbg_lock) begin
            if (LockMax <= 8'd1) begin
                state_d    = StShared;
                lock_cnt_d = 8'd0;
                mask_d     = 1'b1;
            end else begin
                state_d    = StLock;
                lock_cnt_d = 8'd1;
            end
        end else begin
            state_d    = StShared;
            lock_cnt_d = 8'd0;
        end
    end

    // Read data is steered by the owner registered at grant time.
    always_comb begin
        if (ow_dbg_gnt && !iw_dbg_we) begin
            pend_d = PendDbg;
        end else if (ow_cpu_gnt && !iw_cpu_we) begin
            pend_d = PendCpu;
        end else begin
            pend_d = PendNone;
        end
        or_cpu_rvalid = (pend_q == PendCpu);
        or_dbg_rvalid = (pend_q == PendDbg);
        or_cpu_rdata  = or_cpu_rvalid ? iw_mem_rdata : cpu_rdata_q;
        or_dbg_rdata  = or_dbg_rvalid ? iw_mem_rdata : dbg_rdata_q;
        cpu_rdata_d   = or_cpu_rdata;
        dbg_rdata_d   = or_dbg_rdata;
    end

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            state_q     <= StShared;
            pend_q      <= PendNone;
            wait_q      <= 4'd0;
            lock_cnt_q  <= 8'd0;
            mask_q      <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            wait_q      <= wait_d;
            lock_cnt_q  <= lock_cnt_d;
            mask_q      <= mask_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

endmodule

// File: doc/dmem_arb.md
# dmem_arb

Two-requester arbiter for the single-port data memory. It shares the memory between the pipeline's memory-access stage (requester 0, "cpu") and a debug/DMA port (requester 1, "dbg"). CPU has fixed priority. A saturating starvation counter guarantees dbg forward progress, and a lock input lets dbg hold the memory for atomic multi-word sequences. It sits between the MA stage, the debug unit and the data memory, and drives the pipeline stall for MA.

## Interface
Parameters:
- ADDR_WIDTH, 12, data memory word address width.
- DATA_WIDTH, 24, data word width.
- STARVE_LIMIT, 4, consecutive denied dbg cycles before dbg is forced to win; range 1..15.
- LOCK_MAX, 8, maximum consecutive locked dbg grants before a forced one-cycle release; range 1..255.

Ports:
- iw_clk, in, 1, clock; all state updates on rising edge.
- iw_rst_n, in, 1, asynchronous active-low reset.
- iw_cpu_req / iw_cpu_we, in, 1/1, cpu access request / write enable.
- iw_cpu_addr / iw_cpu_wdata, in, ADDR_WIDTH/DATA_WIDTH, cpu address / write data.
- ow_cpu_gnt, out, 1, cpu access accepted this cycle (combinational).
- ow_cpu_stall, out, 1, iw_cpu_req & ~ow_cpu_gnt.
- or_cpu_rvalid / or_cpu_rdata, out, 1/DATA_WIDTH, cpu read data valid / data.
- iw_dbg_req / iw_dbg_we / iw_dbg_lock, in, 1/1/1, dbg request / write enable / hold ownership.
- iw_dbg_addr / iw_dbg_wdata, in, ADDR_WIDTH/DATA_WIDTH, dbg address / write data.
- ow_dbg_gnt, out, 1, dbg access accepted this cycle (combinational).
- or_dbg_rvalid / or_dbg_rdata, out, 1/DATA_WIDTH, dbg read data valid / data.
- ow_mem_en / ow_mem_we, out, 1/1, memory enable / write enable.
- ow_mem_addr / ow_mem_wdata, out, ADDR_WIDTH/DATA_WIDTH, muxed winner address / data.
- iw_mem_rdata, in, DATA_WIDTH, memory read data; valid one cycle after a read enable.

## Operation
- At most one grant per cycle. The winner's addr/we/wdata drive the memory. With no winner, ow_mem_en=0 and addr/wdata=0.
- States:
  - S_SHARED: arbitration active.
  - S_LOCK: dbg owns the memory.
- S_SHARED arbitration:
  - Dbg wins if iw_dbg_req and (~iw_cpu_req or r_wait==STARVE_LIMIT).
  - Otherwise cpu wins if iw_cpu_req.
- r_wait (4-bit):
  - Increments, saturating at STARVE_LIMIT, each cycle iw_dbg_req=1 and ow_dbg_gnt=0.
  - Clears on a dbg grant or when iw_dbg_req=0.
- Entering and leaving S_LOCK:
  - S_SHARED→S_LOCK when dbg is granted with iw_dbg_lock=1.
  - In S_LOCK, cpu is never granted. Dbg is granted whenever iw_dbg_req=1.
  - r_lock_cnt counts dbg grants in S_LOCK, including the entering grant.
  - S_LOCK→S_SHARED when iw_dbg_lock=0 (evaluated each cycle, that cycle's arbitration already as S_SHARED), or when r_lock_cnt reaches LOCK_MAX.
- Forced release (r_lock_cnt reaches LOCK_MAX): the next cycle is S_SHARED with dbg masked, so cpu wins if requesting. Arbitration is normal thereafter.
- Read return:
  - A granted read (we=0) sets r_pend to the owner (none/cpu/dbg) for the next cycle.
  - That cycle the owner's rvalid=1 and its rdata is captured from iw_mem_rdata and held until the next valid.
  - Writes produce no rvalid.
- Simultaneous events: a read return and a new grant in the same cycle are independent. A back-to-back read by alternating requesters returns each to its own port.

## Timing
- Grant, stall and memory command are combinational from requests and registered state. There is no bubble between consecutive grants.
- Read latency is 1 cycle: grant at cycle N, rvalid/rdata at cycle N+1.
- Reset (asynchronous on iw_rst_n=0):
  - State=S_SHARED; r_wait=0, r_lock_cnt=0, r_pend=none.
  - or_cpu_rvalid=0, or_dbg_rvalid=0, or_cpu_rdata=0, or_dbg_rdata=0.
  - All combinational outputs are 0 while requests are 0.
- Reset asserted mid-read discards the pending return; no rvalid follows reset release.
- Requests must be held until granted. Deasserting without a grant is legal and clears r_wait for dbg.

## Test plan
- Cpu read addr 0x005, memory returns 0x00ABCD: ow_cpu_gnt=1, ow_mem_addr=0x005, ow_mem_we=0; next cycle or_cpu_rvalid=1, or_cpu_rdata=0x00ABCD, or_dbg_rvalid=0.
- Cpu and dbg both requesting continuously, STARVE_LIMIT=4: cpu granted 4 cycles, ow_cpu_stall=0; cycle 5 ow_dbg_gnt=1, ow_cpu_stall=1; cycle 6 cpu granted and r_wait=0.
- Dbg lock with dbg write 0x0FF0 then read 0x0FF0, cpu requesting throughout: ow_cpu_stall=1 both cycles; dbg read returns the written value; lock drop releases cpu the same cycle.
- LOCK_MAX=8, dbg holds lock and requests for 12 cycles: 8 dbg grants, then exactly one cpu grant, then dbg is granted again.
- Cpu read, then dbg read the next cycle (addr 0x001 → 0x111, addr 0x002 → 0x222): or_cpu_rdata=0x111 at N+1, or_dbg_rdata=0x222 at N+2, never crossed.
- iw_rst_n pulsed low the cycle after a granted read: no rvalid afterwards; all registered outputs 0; state S_SHARED.
